// File: rtl/cla_adder_pipe_if.sv
// cla_adder_pipe_if: operand/result stream bundle for cla_adder_pipe.
// The master produces operands and consumes results; the slave is the adder.
interface cla_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined two-level carry-lookahead adder/subtractor with valid/ready.
// Define CLA_PIPE_SAT_EN to saturate the sum to the signed limit on overflow.
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic            clk,
    input logic            rst,
    cla_adder_pipe_if.slave bus
);
    localparam int NGRP = WIDTH / BLOCK;

    // Group generate as a flat sum of products over the group's bits.
    function automatic logic blk_gen(input logic [BLOCK-1:0] g, input logic [BLOCK-1:0] p);
        logic r;
        logic t;
        r = 1'b0;
        for (int j = 0; j < BLOCK; j++) begin
            t = g[j];
            for (int k = j + 1; k < BLOCK; k++) t = t & p[k];
            r = r | t;
        end
        return r;
    endfunction

    // Carry into every bit of a group, each one a flat sum of products of c.
    function automatic logic [BLOCK-1:0] blk_car(input logic [BLOCK-1:0] g, input logic [BLOCK-1:0] p,
                                                 input logic c);
        logic [BLOCK-1:0] r;
        logic             t;
        r = '0;
        for (int i = 0; i < BLOCK; i++) begin
            t = c;
            for (int j = 0; j < i; j++) t = t & p[j];
            r[i] = t;
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int k = j + 1; k < i; k++) t = t & p[k];
                r[i] = r[i] | t;
            end
        end
        return r;
    endfunction

    function automatic logic [NGRP:0] grp_car(input logic [NGRP-1:0] gg, input logic [NGRP-1:0] gp,
                                              input logic c);
        logic [NGRP:0] r;
        logic          t;
        r = '0;
        for (int i = 0; i <= NGRP; i++) begin
            t = c;
            for (int j = 0; j < i; j++) t = t & gp[j];
            r[i] = t;
            for (int j = 0; j < i; j++) begin
                t = gg[j];
                for (int k = j + 1; k < i; k++) t = t & gp[k];
                r[i] = r[i] | t;
            end
        end
        return r;
    endfunction

    logic             en;
    logic             acc;
    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [NGRP-1:0]  gg_in;
    logic [NGRP-1:0]  gp_in;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NGRP-1:0]  s1_gg;
    logic [NGRP-1:0]  s1_gp;
    logic             s1_c0;

    logic [NGRP:0]    gcar;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] raw;
    logic             ovf_nx;
    logic [WIDTH-1:0] sum_nx;

    logic             out_valid;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign en           = !out_valid | bus.out_ready;
    assign bus.in_ready = en & !rst;
    assign acc          = bus.in_valid & bus.in_ready;

    assign bx   = bus.sub ? ~bus.b : bus.b;
    assign c0   = bus.sub | bus.cin;
    assign p_in = bus.a ^ bx;
    assign g_in = bus.a & bx;

    for (genvar k = 0; k < NGRP; k++) begin : g_s1
        assign gg_in[k] = blk_gen(g_in[k*BLOCK +: BLOCK], p_in[k*BLOCK +: BLOCK]);
        assign gp_in[k] = &p_in[k*BLOCK +: BLOCK];
    end

    assign gcar = grp_car(s1_gg, s1_gp, s1_c0);

    for (genvar k = 0; k < NGRP; k++) begin : g_s2
        assign carry[k*BLOCK +: BLOCK] = blk_car(s1_g[k*BLOCK +: BLOCK], s1_p[k*BLOCK +: BLOCK], gcar[k]);
    end

    assign raw    = s1_p ^ carry;
    assign ovf_nx = carry[WIDTH-1] ^ gcar[NGRP];

`ifdef CLA_PIPE_SAT_EN
    logic s1_amsb;

    // Saturation direction follows a's sign: overflow only happens when both operands share it.
    assign sum_nx = ovf_nx ? {s1_amsb, {(WIDTH-1){~s1_amsb}}} : raw;

    always_ff @(posedge clk) begin
        if (en) s1_amsb <= bus.a[WIDTH-1];
    end
`else
    assign sum_nx = raw;
`endif

    always_ff @(posedge clk) begin
        if (en) begin
            s1_p  <= p_in;
            s1_g  <= g_in;
            s1_gg <= gg_in;
            s1_gp <= gp_in;
            s1_c0 <= c0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (en) begin
            s1_valid  <= acc;
            out_valid <= s1_valid;
            sum_q     <= sum_nx;
            cout_q    <= gcar[NGRP];
            ovf_q     <= ovf_nx;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: scoreboard bench for cla_adder_pipe (WIDTH=16, BLOCK=4).
// Expected results are queued on accept and popped by an independent output monitor.
module tb_cla_adder_pipe;
    localparam int W = 16;
`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef logic [W+1:0] res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_adder_pipe_if #(.WIDTH(W)) bus ();
    cla_adder_pipe #(.WIDTH(W), .BLOCK(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    res_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, overflow from operand/result signs.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                   input logic sub);
        logic [W-1:0] bx;
        logic [W:0]   r;
        logic         ovf;
        logic [W-1:0] s;
        bx  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, bx} + (sub ? 17'd1 : {16'd0, cin});
        ovf = (a[W-1] == bx[W-1]) && (r[W-1] != a[W-1]);
        s   = r[W-1:0];
        if (SAT && ovf) s = a[W-1] ? 16'h8000 : 16'h7FFF;
        return {ovf, r[W], s};
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                        input res_t e);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        if (bus.in_ready) exp_q.push_back(e);
    endtask

    task automatic send_r();
        logic [W-1:0] a = W'($urandom);
        logic [W-1:0] b = W'($urandom);
        logic         c = 1'($urandom);
        logic         s = 1'($urandom);
        send(a, b, c, s, model(a, b, c, s));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin : monitor
        res_t prev;
        res_t cur;
        logic stalled = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cur = {bus.ovf, bus.cout, bus.sum};
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (bus.out_valid && !bus.out_ready) begin
                    check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
                    if (stalled) check("stall_hold", cur, prev);
                    stalled = 1'b1;
                    prev = cur;
                end else begin
                    stalled = 1'b0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) check("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
                    else begin
                        check("result", cur, exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", {bus.ovf, bus.cout, bus.sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        send(16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("latency_edge1", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("latency_edge2", {31'd0, bus.out_valid}, 32'd1);
        drain();

        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
        send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send(16'h0007, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0002});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, SAT ? 16'h7FFF : 16'h8000});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, SAT ? 16'h8000 : 16'h7FFF});
        send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, SAT ? 16'h8000 : 16'h0000});
        idle();
        drain();

        base = pops;
        fork
            for (int i = 0; i < 8; i++) send_r();
            begin
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        idle();
        drain();
        check("stream_count", pops - base, 8);

        base = pops;
        fork
            for (int i = 0; i < 40; i++) send_r();
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        idle();
        drain();
        check("soak_count", pops - base, 40);

        @(negedge clk);
        bus.out_ready = 1'b0;
        send_r();
        send_r();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        base = pops;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("flush_quiet", {31'd0, bus.out_valid}, 32'd0);
        end
        send_r();
        idle();
        drain();
        check("after_flush_count", pops - base, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
